// File: rtl/network_sink.sv
// Turns per-timestep network fire flags into the host packet stream: SPK per fired output,
// run-length STP/SNC packets for closed timesteps.
package network_config;
    localparam int unsigned NUM_OUT = 4;
endpackage

module network_sink #(
    parameter int unsigned PKT_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               arstn,
    input  logic                               net_valid,
    output logic                               net_ready,
    input  logic                               net_last,
    input  logic [network_config::NUM_OUT-1:0] net_out,
    input  logic                               snk_ready,
    output logic                               snk_valid,
    output logic [PKT_WIDTH-1:0]               snk
);
    localparam int unsigned NUM_OUT   = network_config::NUM_OUT;
    localparam int unsigned RUN_WIDTH = PKT_WIDTH - 2;
    localparam int unsigned IDX_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [RUN_WIDTH-1:0] MAX = '1;
    localparam logic [RUN_WIDTH-1:0] ONE = RUN_WIDTH'(1);
    localparam logic [1:0] OP_SPK = 2'b01;
    localparam logic [1:0] OP_STP = 2'b10;
    localparam logic [1:0] OP_SNC = 2'b11;

    typedef enum logic [1:0] {IDLE, FLUSH, SPIKE, TAIL} state_t;

    state_t               state, state_nxt;
    logic [RUN_WIDTH-1:0] pend, pend_nxt;
    logic [NUM_OUT-1:0]   fire, fire_nxt;
    logic                 last, last_nxt;
    logic                 snk_valid_nxt;
    logic [PKT_WIDTH-1:0] snk_nxt;
    logic                 accept_c;

    // Index of the lowest set fire flag; SPK packets go out in ascending index order.
    function automatic logic [IDX_W-1:0] low_idx(input logic [NUM_OUT-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(NUM_OUT) - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [PKT_WIDTH-1:0] spk_pkt(input logic [NUM_OUT-1:0] v);
        return {OP_SPK, RUN_WIDTH'(low_idx(v))};
    endfunction

    function automatic logic [PKT_WIDTH-1:0] run_pkt(input logic snc, input logic [RUN_WIDTH-1:0] n);
        return {(snc ? OP_SNC : OP_STP), n};
    endfunction

    assign net_ready = arstn && (state == IDLE);
    assign accept_c  = net_valid && net_ready;

    // State names the packet held in the output register; a handshake loads the next one.
    always_comb begin
        state_nxt     = state;
        pend_nxt      = pend;
        fire_nxt      = fire;
        last_nxt      = last;
        snk_valid_nxt = snk_valid;
        snk_nxt       = snk;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    last_nxt = net_last;
                    if (net_out != '0) begin
                        snk_valid_nxt = 1'b1;
                        if (pend != '0) begin
                            state_nxt = FLUSH;
                            snk_nxt   = run_pkt(1'b0, pend);
                            pend_nxt  = '0;
                            fire_nxt  = net_out;
                        end else begin
                            state_nxt = SPIKE;
                            snk_nxt   = spk_pkt(net_out);
                            fire_nxt  = net_out & (net_out - NUM_OUT'(1));
                        end
                    end else begin
                        pend_nxt = pend + ONE;
                        if (net_last || (pend_nxt == MAX)) begin
                            state_nxt     = TAIL;
                            snk_nxt       = run_pkt(net_last, pend_nxt);
                            snk_valid_nxt = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (snk_ready) begin
                    state_nxt = SPIKE;
                    snk_nxt   = spk_pkt(fire);
                    fire_nxt  = fire & (fire - NUM_OUT'(1));
                end
            end
            SPIKE: begin
                if (snk_ready) begin
                    if (fire != '0) begin
                        snk_nxt  = spk_pkt(fire);
                        fire_nxt = fire & (fire - NUM_OUT'(1));
                    end else begin
                        // The spiking step itself becomes the first closed step of the next run.
                        pend_nxt = ONE;
                        if (last || (MAX == ONE)) begin
                            state_nxt = TAIL;
                            snk_nxt   = run_pkt(last, ONE);
                        end else begin
                            state_nxt     = IDLE;
                            snk_valid_nxt = 1'b0;
                        end
                    end
                end
            end
            TAIL: begin
                if (snk_ready) begin
                    state_nxt     = IDLE;
                    pend_nxt      = '0;
                    snk_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state     <= IDLE;
            pend      <= '0;
            fire      <= '0;
            last      <= 1'b0;
            snk_valid <= 1'b0;
            snk       <= '0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            fire      <= fire_nxt;
            last      <= last_nxt;
            snk_valid <= snk_valid_nxt;
            snk       <= snk_nxt;
        end
    end
endmodule

// File: tb/tb_network_sink.sv
// Bench for network_sink: table of timesteps with hand-derived packets fed through an
// expected-packet queue, plus hand sequences for saturation, backpressure and reset.
module tb_network_sink;
    logic       clk;
    logic       arstn;
    logic       net_valid;
    logic       net_ready;
    logic       net_last;
    logic [3:0] net_out;
    logic       snk_ready;
    logic       snk_valid;
    logic [7:0] snk;

    network_sink #(.PKT_WIDTH(8)) dut (
        .clk(clk), .arstn(arstn), .net_valid(net_valid), .net_ready(net_ready),
        .net_last(net_last), .net_out(net_out), .snk_ready(snk_ready),
        .snk_valid(snk_valid), .snk(snk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] f;
        logic       l;
        int         n;
        logic [7:0] p[4];
    } vec_t;

    vec_t       tbl[10];
    logic [7:0] q[$];
    int         n_vec;
    int         n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: packet scoreboard at the negedge, then return 1 unit after the posedge.
    task automatic cyc();
        logic [7:0] e;
        @(negedge clk);
        if (arstn && snk_valid && snk_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pkt: got %02h expected none", snk);
            end else begin
                e = q.pop_front();
                check("pkt", 32'(snk), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_step(input logic [3:0] f, input logic l);
        int k;
        k = 0;
        net_valid = 1'b1;
        net_out   = f;
        net_last  = l;
        while (!net_ready && k < 300) begin
            cyc();
            k++;
        end
        if (k >= 300) check("accept_timeout", 32'(k), 32'(0));
        cyc();
        net_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (!(q.size() == 0 && net_ready && !snk_valid) && k < 300) begin
            cyc();
            k++;
        end
        check("drain_left", 32'(q.size()), 32'(0));
        check("drain_valid", 32'(snk_valid), 32'(0));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        tbl[0] = '{4'b1010, 1'b0, 2, '{8'h41, 8'h43, 8'h00, 8'h00}};
        tbl[1] = '{4'b0001, 1'b1, 3, '{8'h81, 8'h40, 8'hC1, 8'h00}};
        for (int i = 2; i < 7; i++) tbl[i] = '{4'b0000, 1'b0, 0, '{8'h00, 8'h00, 8'h00, 8'h00}};
        tbl[7] = '{4'b0010, 1'b1, 3, '{8'h85, 8'h41, 8'hC1, 8'h00}};
        tbl[8] = '{4'b0101, 1'b0, 2, '{8'h40, 8'h42, 8'h00, 8'h00}};
        tbl[9] = '{4'b0000, 1'b1, 1, '{8'hC2, 8'h00, 8'h00, 8'h00}};

        arstn     = 1'b0;
        net_valid = 1'b0;
        net_last  = 1'b0;
        net_out   = 4'b0000;
        snk_ready = 1'b1;
        repeat (3) cyc();
        check("rst_valid", 32'(snk_valid), 32'(0));
        check("rst_snk", 32'(snk), 32'(0));
        check("rst_ready", 32'(net_ready), 32'(0));
        arstn = 1'b1;
        #1;
        check("ready_after_rst", 32'(net_ready), 32'(1));

        // Table: mixed spike/empty steps, back-to-back empty steps keep net_ready high.
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < tbl[i].n; j++) q.push_back(tbl[i].p[j]);
            send_step(tbl[i].f, tbl[i].l);
            if (tbl[i].n == 0) begin
                check("empty_ready", 32'(net_ready), 32'(1));
                check("empty_valid", 32'(snk_valid), 32'(0));
            end
            drain();
        end

        // 63 empty steps saturate the run counter into a single STP(63).
        for (int i = 0; i < 63; i++) begin
            if (i == 62) q.push_back(8'hBF);
            send_step(4'b0000, 1'b0);
            if (i < 62) begin
                check("sat_ready", 32'(net_ready), 32'(1));
            end else begin
                check("sat_ready_low", 32'(net_ready), 32'(0));
                check("sat_valid", 32'(snk_valid), 32'(1));
            end
        end
        drain();
        send_step(4'b0000, 1'b0);
        q.push_back(8'hC2);
        send_step(4'b0000, 1'b1);
        drain();

        // Two empty steps closed by an empty last step.
        send_step(4'b0000, 1'b0);
        send_step(4'b0000, 1'b0);
        q.push_back(8'hC3);
        send_step(4'b0000, 1'b1);
        drain();

        // Backpressure after the second SPK of an all-fire step.
        for (int j = 0; j < 4; j++) q.push_back(8'(8'h40 + j));
        send_step(4'b1111, 1'b0);
        cyc();
        cyc();
        snk_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("stall_snk", 32'(snk), 32'h42);
            check("stall_valid", 32'(snk_valid), 32'(1));
            check("stall_ready", 32'(net_ready), 32'(0));
        end
        snk_ready = 1'b1;
        drain();
        q.push_back(8'hC2);
        send_step(4'b0000, 1'b1);
        drain();

        // Reset in the middle of a spike burst drops the rest of it.
        q.push_back(8'h40);
        send_step(4'b1111, 1'b0);
        cyc();
        arstn = 1'b0;
        #1;
        check("midrst_ready", 32'(net_ready), 32'(0));
        cyc();
        arstn = 1'b1;
        #1;
        check("midrst_valid", 32'(snk_valid), 32'(0));
        check("midrst_snk", 32'(snk), 32'(0));
        q.push_back(8'h40);
        q.push_back(8'hC1);
        send_step(4'b0001, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
